// File: rtl/rca_nibble_sequencer.sv
// Sequences a 4-bit combinational ripple_carry_adder over NIBBLES nibbles, injecting carry via a second pass.
// Optional RCA_SKIP_ZERO_CARRY_EN: nibbles entered with zero carry skip the carry pass.
module rca_nibble_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    output logic [3:0]           rca_in0,
    output logic [3:0]           rca_in1,
    input  logic [3:0]           rca_out,
    input  logic                 rca_cout,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 carry_out,
    output logic                 done
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_CARRY,
        S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_q, b_q;
    logic [3:0]      t_q;
    logic            c_q, c1_q;
    logic [IW-1:0]   i_q;
    logic [IW+1:0]   base;
    logic            last;
    logic            c_new;

    assign base  = {i_q, 2'b00};
    assign last  = (i_q == LAST);
    assign c_new = c1_q | rca_cout;

    always_comb begin
        state_nx    = state;
        rca_in0     = '0;
        rca_in1     = '0;
        start_ready = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nx = S_ADD;
            end
            S_ADD: begin
                rca_in0 = a_q[base +: 4];
                rca_in1 = b_q[base +: 4];
`ifdef RCA_SKIP_ZERO_CARRY_EN
                if (!c_q) state_nx = last ? S_DONE : S_ADD;
                else      state_nx = S_CARRY;
`else
                state_nx = S_CARRY;
`endif
            end
            S_CARRY: begin
                rca_in0  = t_q;
                rca_in1  = {3'b000, c_q};
                state_nx = last ? S_DONE : S_ADD;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            t_q       <= '0;
            c_q       <= 1'b0;
            c1_q      <= 1'b0;
            i_q       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        a_q       <= op_a;
                        b_q       <= op_b;
                        c_q       <= cin;
                        i_q       <= '0;
                        sum       <= '0;
                        carry_out <= 1'b0;
                    end
                end
                S_ADD: begin
`ifdef RCA_SKIP_ZERO_CARRY_EN
                    // With no incoming carry the first pass is already the final nibble result.
                    if (!c_q) begin
                        sum[base +: 4] <= rca_out;
                        c_q            <= rca_cout;
                        if (last) carry_out <= rca_cout;
                        else      i_q       <= i_q + 1'b1;
                    end else begin
                        t_q  <= rca_out;
                        c1_q <= rca_cout;
                    end
`else
                    t_q  <= rca_out;
                    c1_q <= rca_cout;
`endif
                end
                S_CARRY: begin
                    sum[base +: 4] <= rca_out;
                    c_q            <= c_new;
                    if (last) carry_out <= c_new;
                    else      i_q       <= i_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Directed self-checking bench for rca_nibble_sequencer (NIBBLES=4) with a behavioural 4-bit adder.
module tb_rca_nibble_sequencer;

    localparam int N = 4;
`ifdef RCA_SKIP_ZERO_CARRY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] op_a, op_b;
    logic        cin;
    logic [3:0]  rca_in0, rca_in1, rca_out;
    logic        rca_cout;
    logic [15:0] sum;
    logic        carry_out;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign {rca_cout, rca_out} = {1'b0, rca_in0} + {1'b0, rca_in1};

    rca_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .cin        (cin),
        .rca_in0    (rca_in0),
        .rca_in1    (rca_in1),
        .rca_out    (rca_out),
        .rca_cout   (rca_cout),
        .sum        (sum),
        .carry_out  (carry_out),
        .done       (done)
    );

    // Cycle (counted from 1 after the accepting edge) in which done is expected.
    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b, input logic ci);
        int cnt;
        logic c;
        logic [4:0] s;
        cnt = 0;
        c   = ci;
        for (int n = 0; n < N; n++) begin
            if (c) cnt++;
            s = {1'b0, a[4*n +: 4]} + {1'b0, b[4*n +: 4]} + {4'b0000, c};
            c = s[4];
        end
        return SKIP ? (N + cnt + 1) : (2 * N + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge; on return the bench sits in cycle 1 after the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci);
        start_valid = 1'b1;
        op_a = a;
        op_b = b;
        cin  = ci;
        tick();
        start_valid = 1'b0;
        op_a = ~a;
        op_b = ~b;
        cin  = ~ci;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        cin  = 1'b0;
        #12;
        checks++;
        if ({sum, carry_out, done, rca_in0, rca_in1, start_ready} !== {16'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs: got sum=%h co=%b done=%b in0=%h in1=%h rdy=%b expected 0 0 0 0 0 1",
                     sum, carry_out, done, rca_in0, rca_in1, start_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (start_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b done=%b expected rdy=1 done=0", start_ready, done);
        end
    endtask

    task automatic test_basic();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vc [5];
        logic [15:0] vs [5];
        logic        vco[5];
        int lat;
        va = '{16'h0000, 16'hFFFF, 16'h000F, 16'hFFFF, 16'h8000};
        vb = '{16'h0009, 16'h0001, 16'h0000, 16'hFFFF, 16'h8000};
        vc = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
        vs = '{16'h0009, 16'h0000, 16'h0010, 16'hFFFF, 16'h0000};
        vco = '{1'b0,    1'b1,     1'b0,     1'b1,     1'b1};
        for (int v = 0; v < 5; v++) begin
            start_op(va[v], vb[v], vc[v]);
            wait_done(lat);
            checks++;
            if (lat != exp_lat(va[v], vb[v], vc[v])) begin
                failures++;
                $display("FAIL basic_latency[%0d]: got %0d expected %0d", v, lat, exp_lat(va[v], vb[v], vc[v]));
            end
            checks++;
            if (sum !== vs[v] || carry_out !== vco[v]) begin
                failures++;
                $display("FAIL basic_result[%0d]: got %b_%h expected %b_%h", v, carry_out, sum, vco[v], vs[v]);
            end
            tick();
            checks++;
            if (done !== 1'b0 || start_ready !== 1'b1 || sum !== vs[v]) begin
                failures++;
                $display("FAIL basic_after_done[%0d]: got done=%b rdy=%b sum=%h expected 0 1 %h",
                         v, done, start_ready, sum, vs[v]);
            end
        end
    endtask

    task automatic test_rca_drive();
        logic [3:0] e0 [4];
        logic [3:0] e1 [4];
        int stride;
        e0 = '{4'h4, 4'h3, 4'h2, 4'h1};
        e1 = '{4'h1, 4'h2, 4'h3, 4'h4};
        stride = SKIP ? 1 : 2;
        start_op(16'h1234, 16'h4321, 1'b0);
        for (int n = 0; n < N; n++) begin
            checks++;
            if (rca_in0 !== e0[n] || rca_in1 !== e1[n]) begin
                failures++;
                $display("FAIL drive_add[%0d]: got %h/%h expected %h/%h", n, rca_in0, rca_in1, e0[n], e1[n]);
            end
            if (!SKIP) begin
                tick();
                checks++;
                if (rca_in0 !== 4'h5 || rca_in1 !== 4'h0) begin
                    failures++;
                    $display("FAIL drive_carry[%0d]: got %h/%h expected 5/0", n, rca_in0, rca_in1);
                end
                tick();
            end else begin
                tick();
            end
        end
        checks++;
        if (done !== 1'b1 || sum !== 16'h5555 || carry_out !== 1'b0 || rca_in0 !== 4'h0 || rca_in1 !== 4'h0) begin
            failures++;
            $display("FAIL drive_done: got done=%b sum=%h co=%b in=%h/%h expected 1 5555 0 0/0",
                     done, sum, carry_out, rca_in0, rca_in1);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        int lat;
        bit saw_ready;
        saw_ready = 1'b0;
        start_op(16'h1111, 16'h2222, 1'b0);
        start_valid = 1'b1;
        op_a = 16'hFFFF;
        op_b = 16'hFFFF;
        cin  = 1'b1;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (start_ready !== 1'b0) saw_ready = 1'b1;
            tick();
            lat++;
        end
        start_valid = 1'b0;
        checks++;
        if (saw_ready) begin
            failures++;
            $display("FAIL busy_ready: got start_ready=1 while busy expected 0");
        end
        checks++;
        if (done !== 1'b1 || sum !== 16'h3333 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL busy_result: got done=%b %b_%h expected 1 0_3333", done, carry_out, sum);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(16'h1111, 16'h2222, 1'b0);
        start_valid = 1'b1;
        op_a = 16'h00FF;
        op_b = 16'h0001;
        cin  = 1'b0;
        wait_done(lat);
        checks++;
        if (lat != exp_lat(16'h1111, 16'h2222, 1'b0) || sum !== 16'h3333) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d sum=%h expected %0d 3333", lat, sum, exp_lat(16'h1111, 16'h2222, 1'b0));
        end
        tick();
        checks++;
        if (start_ready !== 1'b1 || sum !== 16'h3333) begin
            failures++;
            $display("FAIL b2b_idle: got rdy=%b sum=%h expected 1 3333", start_ready, sum);
        end
        tick();
        start_valid = 1'b0;
        checks++;
        if (start_ready !== 1'b0 || sum !== 16'h0000) begin
            failures++;
            $display("FAIL b2b_accept: got rdy=%b sum=%h expected 0 0000", start_ready, sum);
        end
        wait_done(lat);
        checks++;
        if (lat != exp_lat(16'h00FF, 16'h0001, 1'b0) || sum !== 16'h0100 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d %b_%h expected %0d 0_0100",
                     lat, carry_out, sum, exp_lat(16'h00FF, 16'h0001, 1'b0));
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int lat;
        int ndone;
        start_op(16'h1234, 16'h4321, 1'b0);
        for (int k = 1; k < (SKIP ? 3 : 5); k++) tick();
        checks++;
        if (rca_in0 !== 4'h2 || rca_in1 !== 4'h3) begin
            failures++;
            $display("FAIL midrst_position: got %h/%h expected 2/3", rca_in0, rca_in1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sum, carry_out, done, rca_in0, rca_in1, start_ready} !== {16'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1}) begin
            failures++;
            $display("FAIL midrst_outputs: got sum=%h co=%b done=%b in0=%h in1=%h rdy=%b expected 0 0 0 0 0 1",
                     sum, carry_out, done, rca_in0, rca_in1, start_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || sum !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_no_done: got pulses=%0d sum=%h expected 0 0000", ndone, sum);
        end
        start_op(16'h0F0F, 16'h0101, 1'b1);
        wait_done(lat);
        checks++;
        if (lat != exp_lat(16'h0F0F, 16'h0101, 1'b1) || sum !== 16'h1011 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_recover: got lat=%0d %b_%h expected %0d 0_1011",
                     lat, carry_out, sum, exp_lat(16'h0F0F, 16'h0101, 1'b1));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rca_drive();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
